// File: rtl/axi_noc_pkg.sv
// rtl/axi_noc_pkg.sv - shared constants for the NoC write split/merge blocks
// Purpose: source index encoding and the layout of the source tag carried in
// the upper downstream ID bits. The tag occupies id[IDWID +: SRC_W], and the
// same tag value rebuilds the top ADDR_REBUILD_BITS of the downstream address.
// Ports: none (package).
package axi_noc_pkg;

    localparam int NUM_SRC           = 4;
    localparam int SRC_W             = 2;
    localparam int ADDR_REBUILD_BITS = 2;

    typedef enum logic [SRC_W-1:0] {
        SRC_A = 2'd0,
        SRC_B = 2'd1,
        SRC_C = 2'd2,
        SRC_D = 2'd3
    } src_e;

endpackage

// File: rtl/axi_wr_4_merger_rr_arb4.sv
// rtl/axi_wr_4_merger_rr_arb4.sv - 4-request round-robin arbiter (rr_arb4)
// Purpose: one-hot grant searching from a pointer; the pointer moves to the
// slot after the winner on every grant. Reset points at source a.
// Ports: clk, rst_n (sync active-low), en_i (grant allowed), req_i[3:0],
//        gnt_o[3:0] one-hot, gnt_idx_o winner index, gnt_valid_o.
module rr_arb4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_idx_o,
    output logic       gnt_valid_o
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] cand;

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = 2'd0;
        cand        = 2'd0;
        if (en_i) begin
            for (int k = 0; k < 4; k++) begin
                cand = ptr_q + 2'(k);
                if (!gnt_valid_o && req_i[cand]) begin
                    gnt_valid_o = 1'b1;
                    gnt_idx_o   = cand;
                end
            end
        end
        gnt_o = gnt_valid_o ? (4'b0001 << gnt_idx_o) : 4'b0000;
        ptr_d = gnt_valid_o ? (gnt_idx_o + 2'd1) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= 2'd0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/syncfifo_sampled.sv
// rtl/syncfifo_sampled.sv - small synchronous FIFO with registered storage
// Purpose: ordering FIFO; head entry is read combinationally from storage.
// Push while full is accepted only when a pop happens in the same cycle.
// Ports: clk, rst_n (sync active-low), push_i/push_data_i, pop_i,
//        pop_data_o (head entry), full_o, empty_o.
module syncfifo_sampled #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full_o && !pop_i));
    underflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && empty_o));

endmodule

// File: rtl/axi_wr_4_merger.sv
// rtl/axi_wr_4_merger.sv - 4:1 AXI write-channel merger (a..d onto one target)
// Purpose: round-robin AW arbitration into a one-entry output register; the
// winner index is placed in awid[IDWID+1:IDWID] and awaddr[31:30]. W beats
// follow grant order through an order FIFO; B is steered by the bid tag.
// Optional: AXI_WR_4_MERGER_OUTSTANDING_LIMIT_EN adds per-source outstanding
// counters that mask a source from arbitration at MAX_OUTSTANDING.
// Ports: clk, rst_n; per source x in a..d: x_aw*, x_w*, x_b*;
//        downstream aw*, w*, b* with ID width IDWID+2.
module axi_wr_4_merger
    import axi_noc_pkg::*;
#(
    parameter int EXTRAS          = 8,
    parameter int IDWID           = 4,
    parameter int DWID            = 64,
    parameter int WSTRB           = DWID/8,
    parameter int ORDER_DEPTH     = 8,
    parameter int MAX_OUTSTANDING = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDWID-1:0]   a_awid,    b_awid,    c_awid,    d_awid,
    input  logic [31:0]        a_awaddr,  b_awaddr,  c_awaddr,  d_awaddr,
    input  logic [7:0]         a_awlen,   b_awlen,   c_awlen,   d_awlen,
    input  logic [1:0]         a_awburst, b_awburst, c_awburst, d_awburst,
    input  logic [EXTRAS-1:0]  a_awextras, b_awextras, c_awextras, d_awextras,
    input  logic               a_awvalid, b_awvalid, c_awvalid, d_awvalid,
    output logic               a_awready, b_awready, c_awready, d_awready,
    input  logic [DWID-1:0]    a_wdata,   b_wdata,   c_wdata,   d_wdata,
    input  logic [WSTRB-1:0]   a_wstrb,   b_wstrb,   c_wstrb,   d_wstrb,
    input  logic               a_wlast,   b_wlast,   c_wlast,   d_wlast,
    input  logic               a_wvalid,  b_wvalid,  c_wvalid,  d_wvalid,
    output logic               a_wready,  b_wready,  c_wready,  d_wready,
    output logic [IDWID-1:0]   a_bid,     b_bid,     c_bid,     d_bid,
    output logic [1:0]         a_bresp,   b_bresp,   c_bresp,   d_bresp,
    output logic               a_bvalid,  b_bvalid,  c_bvalid,  d_bvalid,
    input  logic               a_bready,  b_bready,  c_bready,  d_bready,
    output logic [IDWID+1:0]   awid,
    output logic [31:0]        awaddr,
    output logic [7:0]         awlen,
    output logic [1:0]         awburst,
    output logic [EXTRAS-1:0]  awextras,
    output logic               awvalid,
    input  logic               awready,
    output logic [DWID-1:0]    wdata,
    output logic [WSTRB-1:0]   wstrb,
    output logic               wlast,
    output logic               wvalid,
    input  logic               wready,
    input  logic [IDWID+1:0]   bid,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready
);

    // Per-source views of the upstream ports, indexed by source number.
    logic [NUM_SRC-1:0] s_awvalid, s_wvalid, s_wlast, s_bready;
    logic [IDWID-1:0]   s_awid     [NUM_SRC];
    logic [29:0]        s_awaddr   [NUM_SRC];
    logic [7:0]         s_awlen    [NUM_SRC];
    logic [1:0]         s_awburst  [NUM_SRC];
    logic [EXTRAS-1:0]  s_awextras [NUM_SRC];
    logic [DWID-1:0]    s_wdata    [NUM_SRC];
    logic [WSTRB-1:0]   s_wstrb    [NUM_SRC];

    assign s_awvalid = {d_awvalid, c_awvalid, b_awvalid, a_awvalid};
    assign s_wvalid  = {d_wvalid,  c_wvalid,  b_wvalid,  a_wvalid};
    assign s_wlast   = {d_wlast,   c_wlast,   b_wlast,   a_wlast};
    assign s_bready  = {d_bready,  c_bready,  b_bready,  a_bready};
    assign s_awid     = '{a_awid, b_awid, c_awid, d_awid};
    assign s_awaddr   = '{a_awaddr[31:2], b_awaddr[31:2], c_awaddr[31:2], d_awaddr[31:2]};
    assign s_awlen    = '{a_awlen, b_awlen, c_awlen, d_awlen};
    assign s_awburst  = '{a_awburst, b_awburst, c_awburst, d_awburst};
    assign s_awextras = '{a_awextras, b_awextras, c_awextras, d_awextras};
    assign s_wdata    = '{a_wdata, b_wdata, c_wdata, d_wdata};
    assign s_wstrb    = '{a_wstrb, b_wstrb, c_wstrb, d_wstrb};

    // The address rebuild overwrites the two LSBs' worth of shift, so the
    // upstream byte-offset bits are not forwarded.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{a_awaddr[1:0], b_awaddr[1:0], c_awaddr[1:0], d_awaddr[1:0]};

    logic [NUM_SRC-1:0] arb_req, gnt, b_sel;
    logic [SRC_W-1:0]   gnt_idx, w_src, b_tag;
    logic               gnt_valid, aw_load_ok, arb_en;
    logic               ord_full, ord_empty, w_pop;
    logic [NUM_SRC-1:0] w_ready_vec;

    // ---------------- AW arbitration and output register ----------------
    logic               aw_valid_q,   aw_valid_d;
    logic [IDWID+1:0]   aw_id_q,      aw_id_d;
    logic [31:0]        aw_addr_q,    aw_addr_d;
    logic [7:0]         aw_len_q,     aw_len_d;
    logic [1:0]         aw_burst_q,   aw_burst_d;
    logic [EXTRAS-1:0]  aw_extras_q,  aw_extras_d;

    // A new request may enter when the register frees up this cycle; a full
    // order FIFO stops grants so every granted AW has a W ordering slot.
    assign aw_load_ok = !aw_valid_q || awready;
    assign arb_en     = aw_load_ok && !ord_full;

    rr_arb4 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (arb_en),
        .req_i       (arb_req),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign {d_awready, c_awready, b_awready, a_awready} = gnt;

    always_comb begin
        aw_valid_d  = aw_valid_q;
        aw_id_d     = aw_id_q;
        aw_addr_d   = aw_addr_q;
        aw_len_d    = aw_len_q;
        aw_burst_d  = aw_burst_q;
        aw_extras_d = aw_extras_q;
        if (gnt_valid) begin
            aw_valid_d  = 1'b1;
            aw_id_d     = {gnt_idx, s_awid[gnt_idx]};
            aw_addr_d   = {gnt_idx, s_awaddr[gnt_idx]};
            aw_len_d    = s_awlen[gnt_idx];
            aw_burst_d  = s_awburst[gnt_idx];
            aw_extras_d = s_awextras[gnt_idx];
        end else if (awready) begin
            aw_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_valid_q  <= 1'b0;
            aw_id_q     <= '0;
            aw_addr_q   <= '0;
            aw_len_q    <= '0;
            aw_burst_q  <= '0;
            aw_extras_q <= '0;
        end else begin
            aw_valid_q  <= aw_valid_d;
            aw_id_q     <= aw_id_d;
            aw_addr_q   <= aw_addr_d;
            aw_len_q    <= aw_len_d;
            aw_burst_q  <= aw_burst_d;
            aw_extras_q <= aw_extras_d;
        end
    end

    assign awvalid  = aw_valid_q;
    assign awid     = aw_id_q;
    assign awaddr   = aw_addr_q;
    assign awlen    = aw_len_q;
    assign awburst  = aw_burst_q;
    assign awextras = aw_extras_q;

    // ---------------- W ordering ----------------
    syncfifo_sampled #(
        .WIDTH (SRC_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (gnt_valid),
        .push_data_i (gnt_idx),
        .pop_i       (w_pop),
        .pop_data_o  (w_src),
        .full_o      (ord_full),
        .empty_o     (ord_empty)
    );

    assign wvalid      = !ord_empty && s_wvalid[w_src];
    assign wdata       = wvalid ? s_wdata[w_src] : '0;
    assign wstrb       = wvalid ? s_wstrb[w_src] : '0;
    assign wlast       = wvalid && s_wlast[w_src];
    assign w_pop       = wvalid && wready && wlast;
    assign w_ready_vec = (wready && !ord_empty) ? (4'b0001 << w_src) : 4'b0000;
    assign {d_wready, c_wready, b_wready, a_wready} = w_ready_vec;

    // ---------------- B steering ----------------
    assign b_tag  = bid[IDWID +: SRC_W];
    assign b_sel  = bvalid ? (4'b0001 << b_tag) : 4'b0000;
    assign bready = s_bready[b_tag];

    assign {d_bvalid, c_bvalid, b_bvalid, a_bvalid} = b_sel;
    assign a_bid   = b_sel[0] ? bid[IDWID-1:0] : '0;
    assign b_bid   = b_sel[1] ? bid[IDWID-1:0] : '0;
    assign c_bid   = b_sel[2] ? bid[IDWID-1:0] : '0;
    assign d_bid   = b_sel[3] ? bid[IDWID-1:0] : '0;
    assign a_bresp = b_sel[0] ? bresp : 2'b00;
    assign b_bresp = b_sel[1] ? bresp : 2'b00;
    assign c_bresp = b_sel[2] ? bresp : 2'b00;
    assign d_bresp = b_sel[3] ? bresp : 2'b00;

    // ---------------- Outstanding-write limit ----------------
`ifdef AXI_WR_4_MERGER_OUTSTANDING_LIMIT_EN
    logic [7:0]         ost_q [NUM_SRC];
    logic [7:0]         ost_d [NUM_SRC];
    logic [NUM_SRC-1:0] ost_at_max;
    logic [NUM_SRC-1:0] b_ret;

    assign b_ret = b_sel & s_bready;

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            ost_d[k]      = ost_q[k];
            ost_at_max[k] = (ost_q[k] == 8'(MAX_OUTSTANDING));
            if (gnt[k] && !b_ret[k])      ost_d[k] = ost_q[k] + 8'd1;
            else if (!gnt[k] && b_ret[k]) ost_d[k] = ost_q[k] - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!rst_n) ost_q[k] <= 8'd0;
            else        ost_q[k] <= ost_d[k];
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_ost_chk
        ost_underflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(b_ret[g] && ost_q[g] == 8'd0));
    end

    assign arb_req = s_awvalid & ~ost_at_max;
`else
    logic unused_max_outstanding;
    assign unused_max_outstanding = |MAX_OUTSTANDING;
    assign arb_req = s_awvalid;
`endif

endmodule

// File: tb/tb_axi_wr_4_merger.sv
// tb/tb_axi_wr_4_merger.sv - directed self-checking bench for axi_wr_4_merger
// Purpose: linear directed steps covering reset, single write, contention,
// AW backpressure, order FIFO full, B steering and reset mid-burst.
// Ports: none (top-level bench).
module tb_axi_wr_4_merger;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  s_awid     [4];
    logic [31:0] s_awaddr   [4];
    logic [7:0]  s_awlen    [4];
    logic [1:0]  s_awburst  [4];
    logic [7:0]  s_awextras [4];
    logic [3:0]  s_awvalid, s_wlast, s_wvalid, s_bready;
    logic [63:0] s_wdata    [4];
    logic [7:0]  s_wstrb    [4];
    logic [3:0]  o_awready, o_wready, o_bvalid;
    logic [3:0]  o_bid   [4];
    logic [1:0]  o_bresp [4];
    logic [5:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic [7:0]  awextras;
    logic        awvalid, awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [5:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int checks = 0;
    int errors = 0;
    int bcnt [4];
    logic [5:0]  exp_awid   [4] = '{6'h04, 6'h15, 6'h26, 6'h37};
    logic [31:0] exp_awaddr [4] = '{32'h0000_0400, 32'h4000_0800, 32'h8000_0C00, 32'hC000_1000};

    always #5 clk = ~clk;

    axi_wr_4_merger dut (
        .clk(clk), .rst_n(rst_n),
        .a_awid(s_awid[0]), .b_awid(s_awid[1]), .c_awid(s_awid[2]), .d_awid(s_awid[3]),
        .a_awaddr(s_awaddr[0]), .b_awaddr(s_awaddr[1]), .c_awaddr(s_awaddr[2]), .d_awaddr(s_awaddr[3]),
        .a_awlen(s_awlen[0]), .b_awlen(s_awlen[1]), .c_awlen(s_awlen[2]), .d_awlen(s_awlen[3]),
        .a_awburst(s_awburst[0]), .b_awburst(s_awburst[1]), .c_awburst(s_awburst[2]), .d_awburst(s_awburst[3]),
        .a_awextras(s_awextras[0]), .b_awextras(s_awextras[1]), .c_awextras(s_awextras[2]), .d_awextras(s_awextras[3]),
        .a_awvalid(s_awvalid[0]), .b_awvalid(s_awvalid[1]), .c_awvalid(s_awvalid[2]), .d_awvalid(s_awvalid[3]),
        .a_awready(o_awready[0]), .b_awready(o_awready[1]), .c_awready(o_awready[2]), .d_awready(o_awready[3]),
        .a_wdata(s_wdata[0]), .b_wdata(s_wdata[1]), .c_wdata(s_wdata[2]), .d_wdata(s_wdata[3]),
        .a_wstrb(s_wstrb[0]), .b_wstrb(s_wstrb[1]), .c_wstrb(s_wstrb[2]), .d_wstrb(s_wstrb[3]),
        .a_wlast(s_wlast[0]), .b_wlast(s_wlast[1]), .c_wlast(s_wlast[2]), .d_wlast(s_wlast[3]),
        .a_wvalid(s_wvalid[0]), .b_wvalid(s_wvalid[1]), .c_wvalid(s_wvalid[2]), .d_wvalid(s_wvalid[3]),
        .a_wready(o_wready[0]), .b_wready(o_wready[1]), .c_wready(o_wready[2]), .d_wready(o_wready[3]),
        .a_bid(o_bid[0]), .b_bid(o_bid[1]), .c_bid(o_bid[2]), .d_bid(o_bid[3]),
        .a_bresp(o_bresp[0]), .b_bresp(o_bresp[1]), .c_bresp(o_bresp[2]), .d_bresp(o_bresp[3]),
        .a_bvalid(o_bvalid[0]), .b_bvalid(o_bvalid[1]), .c_bvalid(o_bvalid[2]), .d_bvalid(o_bvalid[3]),
        .a_bready(s_bready[0]), .b_bready(s_bready[1]), .c_bready(s_bready[2]), .d_bready(s_bready[3]),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awextras(awextras),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
        for (int x = 0; x < 4; x++) begin
            s_awid[x] = 4'(x + 4);
            s_awaddr[x] = 32'h1000 * (x + 1);
            s_awlen[x] = 8'd3;
            s_awburst[x] = 2'b01;
            s_awextras[x] = 8'(x);
            s_wdata[x] = '0;
            s_wstrb[x] = 8'hFF;
            bcnt[x] = 0;
        end
        awready = 1'b0; wready = 1'b0;
        bid = '0; bresp = '0; bvalid = 1'b0;

        // reset state
        nxt(); nxt(); #1;
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_awready", o_awready, 4'b0000);
        chk("rst_bvalid", o_bvalid, 4'b0000);
        rst_n = 1'b1;

        // single write from a
        nxt();
        s_awid[0] = 4'h3; s_awaddr[0] = 32'h0000_0040; s_awlen[0] = 8'd0;
        s_awextras[0] = 8'h5A; s_awvalid[0] = 1'b1; awready = 1'b1; #1;
        chk("single_awready", o_awready, 4'b0001);
        chk("single_awvalid_lat", awvalid, 1'b0);
        nxt();
        s_awvalid[0] = 1'b0;
        s_wdata[0] = 64'h1122_3344_5566_7788; s_wstrb[0] = 8'hF0;
        s_wlast[0] = 1'b1; s_wvalid[0] = 1'b1; wready = 1'b1; #1;
        chk("single_awvalid", awvalid, 1'b1);
        chk("single_awid", awid, 6'h03);
        chk("single_awaddr", awaddr, 32'h0000_0010);
        chk("single_awlen", awlen, 8'd0);
        chk("single_awextras", awextras, 8'h5A);
        chk("single_wvalid", wvalid, 1'b1);
        chk("single_wdata", wdata, 64'h1122_3344_5566_7788);
        chk("single_wstrb", wstrb, 8'hF0);
        chk("single_wready", o_wready, 4'b0001);
        nxt();
        s_wvalid[0] = 1'b0; s_wlast[0] = 1'b0; #1;
        chk("single_awvalid_done", awvalid, 1'b0);
        chk("single_wvalid_done", wvalid, 1'b0);
        chk("single_wdata_zero", wdata, 64'h0);
        bid = 6'h03; bresp = 2'b00; bvalid = 1'b1; s_bready[0] = 1'b1; #1;
        chk("single_bvalid", o_bvalid, 4'b0001);
        chk("single_bid", o_bid[0], 4'h3);
        chk("single_bready", bready, 1'b1);
        nxt();
        bvalid = 1'b0; s_bready = '0;
        s_awaddr[0] = 32'h1000; s_awid[0] = 4'h4; s_awlen[0] = 8'd3;
        s_wstrb[0] = 8'hFF;

        // contention: fresh pointer, all four request together
        do_reset();
        s_awvalid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_awready", o_awready, 4'b0001 << k);
            if (k > 0) begin
                chk("cont_awid", awid, exp_awid[k-1]);
                chk("cont_awaddr", awaddr, exp_awaddr[k-1]);
            end
            nxt();
            s_awvalid[k] = 1'b0;
        end
        #1;
        chk("cont_awid", awid, exp_awid[3]);
        chk("cont_awaddr", awaddr, exp_awaddr[3]);
        s_wvalid = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            for (int x = 0; x < 4; x++) begin
                s_wdata[x] = {48'h0, 8'(x), 8'(bcnt[x])};
                s_wlast[x] = (bcnt[x] == 3);
            end
            #1;
            chk("cont_wdata", wdata, {48'h0, 8'(i / 4), 8'(i % 4)});
            chk("cont_wlast", wlast, (i % 4) == 3);
            chk("cont_wready", o_wready, 4'b0001 << (i / 4));
            bcnt[i / 4]++;
            nxt();
        end
        s_wvalid = '0; s_wlast = '0; #1;
        chk("cont_drained", wvalid, 1'b0);

        // backpressure: pointer back at a, downstream stalls
        awready = 1'b0;
        s_awvalid = 4'b1111; #1;
        chk("bp_first_grant", o_awready, 4'b0001);
        nxt();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_no_grant", o_awready, 4'b0000);
            chk("bp_awaddr_hold", awaddr, 32'h0000_0400);
            nxt();
        end
        s_awvalid = '0;
        do_reset();

        // order FIFO full: eight AWs from c, W withheld
        awready = 1'b1; wready = 1'b1;
        s_awvalid[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("full_grant", o_awready, 4'b0100);
            nxt();
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("full_stall", o_awready, 4'b0000);
            nxt();
        end
        s_wvalid[2] = 1'b1; s_wlast[2] = 1'b1; #1;
        chk("full_pop_cycle", o_awready, 4'b0000);
        chk("full_c_wready", o_wready, 4'b0100);
        nxt();
        s_wvalid[2] = 1'b0; s_wlast[2] = 1'b0; #1;
        chk("full_resume", o_awready, 4'b0100);
        nxt();
        s_awvalid = '0;
        do_reset();

        // B steering to d with d_bready held low
        bid = 6'h35; bresp = 2'b10; bvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("b_bvalid", o_bvalid, 4'b1000);
            chk("b_bid", o_bid[3], 4'h5);
            chk("b_bresp", o_bresp[3], 2'b10);
            chk("b_bready_low", bready, 1'b0);
            nxt();
        end
        s_bready[3] = 1'b1; #1;
        chk("b_bready_high", bready, 1'b1);
        nxt();
        bid = 6'h1A; bresp = 2'b01; #1;
        chk("b_tag1_bvalid", o_bvalid, 4'b0010);
        chk("b_tag1_bid", o_bid[1], 4'hA);
        nxt();
        bvalid = 1'b0; s_bready = '0; #1;
        chk("b_idle", o_bvalid, 4'b0000);

        // reset mid-burst
        awready = 1'b0;
        s_awvalid[0] = 1'b1; #1;
        chk("mid_grant", o_awready, 4'b0001);
        nxt();
        s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b1; s_wlast[0] = 1'b0; #1;
        chk("mid_beat1", wvalid, 1'b1);
        nxt();
        rst_n = 1'b0; #1;
        chk("mid_beat2", wvalid, 1'b1);
        nxt(); #1;
        chk("mid_rst_wvalid", wvalid, 1'b0);
        chk("mid_rst_awvalid", awvalid, 1'b0);
        chk("mid_rst_wready", o_wready, 4'b0000);
        rst_n = 1'b1; s_wvalid = '0;
        s_awvalid = 4'b0011; #1;
        chk("mid_rr_ptr_a", o_awready, 4'b0001);
        nxt();
        s_awvalid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_wr_4_merger.md
Name: axi_wr_4_merger

Overview:
- 4:1 AXI write-channel merger; the inverse of the NoC write splitter. Four upstream initiator ports (a..d) share one downstream target port.
- AW requests are arbitrated round-robin and tagged with the source index in the upper ID bits; the source index also rebuilds address bits [31:30].
- W beats follow AW grant order through an order FIFO.
- B responses are steered back to the source named by the returned bid tag.

Parameters:
- EXTRAS, 8, width of awextras sideband
- IDWID, 4, upstream ID width; downstream ID width is IDWID+2
- DWID, 64, data width
- WSTRB, DWID/8, strobe width
- ORDER_DEPTH, 8, order FIFO depth (power of 2)
- MAX_OUTSTANDING, 15, per-source outstanding-write limit (optional feature only)

Ports:
- clk input 1 clock
- rst_n input 1 synchronous active-low reset
- x_awid/x_awaddr/x_awlen/x_awburst/x_awextras input IDWID/32/8/2/EXTRAS, upstream AW payload, for x in {a,b,c,d}
- x_awvalid input 1; x_awready output 1 (per x)
- x_wdata/x_wstrb/x_wlast input DWID/WSTRB/1; x_wvalid input 1; x_wready output 1 (per x)
- x_bid output IDWID; x_bresp output 2; x_bvalid output 1; x_bready input 1 (per x)
- awid output IDWID+2; awaddr output 32; awlen output 8; awburst output 2; awextras output EXTRAS; awvalid output 1; awready input 1
- wdata output DWID; wstrb output WSTRB; wlast output 1; wvalid output 1; wready input 1
- bid input IDWID+2; bresp input 2; bvalid input 1; bready output 1

Behaviour:
- Reset: synchronous on rst_n low at posedge clk. Effects:
  - awvalid, wvalid, all x_awready, x_wready, x_bvalid = 0
  - RR pointer = a (priority a>b>c>d)
  - order FIFO and AW output register empty
  - mid-burst reset abandons state; no recovery of partial bursts
- AW output register (1 entry, registered):
  - loadable when empty, or when awvalid&&awready in the same cycle
  - when loadable, the arbiter grants one requesting x (awvalid=1), searching from the RR pointer, provided the order FIFO is not full
  - grant asserts x_awready combinationally for that x only
  - on grant: register loads {x_idx,x_awid}, {x_idx[1:0], x_awaddr[31:2]}, len, burst, extras; x_idx is pushed to the order FIFO; RR pointer = x_idx+1 mod 4
  - awvalid is asserted the cycle after the grant (latency 1)
  - payload is held stable while awvalid&&!awready
- W path:
  - head of the order FIFO selects the source s; wvalid = !order_empty && s_wvalid
  - s_wready = wready && !order_empty; all other x_wready = 0
  - wdata/wstrb/wlast are muxed from s, and are 0 when wvalid=0
  - pop the order FIFO on wvalid&&wready&&wlast
  - W may lead downstream AW by up to one cycle only after its AW is granted; never before the grant
- Order FIFO:
  - push and pop in the same cycle are both allowed, including when full
  - full blocks new grants
  - overflow and underflow are impossible by construction; a simulation assertion flags either
- B path:
  - combinational steer: t = bid[IDWID+1:IDWID]
  - x_bvalid = bvalid && (t==x_idx); x_bid = bid[IDWID-1:0]; x_bresp = bresp for the selected x, else 0
  - bready = t_bready
- Simultaneous AW grant and B return for the same source are independent.
- Zero-length bursts (awlen=0) with a single wlast beat pop the order FIFO in the same cycle as the beat.

Optional Feature:
- Macro: AXI_WR_4_MERGER_OUTSTANDING_LIMIT_EN
- With macro:
  - per-source 8-bit counter: +1 on grant, −1 on x_bvalid&&x_bready, net 0 if both in the same cycle
  - a source whose count == MAX_OUTSTANDING is masked from arbitration
  - counters reset to 0
  - decrement at 0 is an assertion error
- Without macro: no counters; arbitration is unlimited apart from order FIFO backpressure.

Decomposition:
- Package axi_noc_pkg: source index encoding (SRC_A=0..SRC_D=3), the tag field position IDWID, and the address-rebuild constant (2 bits).
- One sub-module, rr_arb4: 4-request round-robin arbiter with pointer register and enable input.
- FIFO: the existing syncfifo_sampled.

Test Plan:
- Single write: a_awaddr=0x0000_0040, awlen=0, 1 beat → downstream awid={2'b00,id}, awaddr=0x0000_0010, awvalid 1 cycle after grant; beat forwarded; bid tag 0 → a_bvalid only.
- Contention: a..d assert awvalid together with awready=1 → grants a,b,c,d on 4 consecutive cycles; W bursts (len 3) are forwarded in that order; no interleave.
- Backpressure: awready=0 for 10 cycles with all ports requesting → only 1 grant plus register hold; awaddr stable; order FIFO depth 1.
- Order FIFO full: 8 AWs from c with W withheld → 9th AW stalls (c_awready=0) until the first wlast handshake pops the FIFO.
- B steering: bid={2'b11,4'h5}, d_bready=0 for 3 cycles → d_bvalid=1, d_bid=5, bready=0, others x_bvalid=0; all release on d_bready=1.
- Reset mid-burst: rst_n low during beat 2 of a 4-beat burst → next cycle wvalid=0, awvalid=0, RR pointer=a, order FIFO empty.
